// File: rtl/slot_bus_master.sv
// Option-slot bus initiator: frames single-register requests into SEL/CMD/REG/DATA/DESEL cycles.
// Optional macro SLOT_POLL_EN enables repeated DATA reads until a stop value or POLL_MAX reads.
module slot_bus_master #(
  parameter int CLK_DIV  = 4,
  parameter int POLL_MAX = 64
) (
  input  logic       clk_20mhz,
  input  logic       reset_x,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  input  logic       req_read,
  input  logic       req_poll,
  input  logic [7:0] poll_until,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       slot_x,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  input  logic [7:0] bus_din,
  input  logic       int_x,
  output logic       irq_sync
);

  // state | meaning
  // IDLE  | bus idle, slot deselected, request accepted here
  // SEL   | select cycle, 0xFF driven with ax_d=0
  // CMD   | command byte cycle
  // REG   | register byte cycle
  // DATA  | data cycle (ax_d=1), repeated while polling
  // DESEL | closing 0xFF cycle, response issued on exit
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_CMD, S_REG, S_DATA, S_DESEL} state_t;

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] PH_LOAD = CNT_W'(CLK_DIV - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] ph_cnt, ph_n;
  logic             clk_rw_n, slot_x_n, ax_d_n, r_wx_n, bus_doe_n;
  logic [7:0]       bus_dout_n;
  logic [7:0]       lat_cmd, lat_reg, lat_wdata, lat_until;
  logic [7:0]       lat_cmd_n, lat_reg_n, lat_wdata_n, lat_until_n;
  logic             lat_read, lat_poll, lat_read_n, lat_poll_n;
  logic [7:0]       rd_data, rd_data_n, poll_cnt, poll_cnt_n;
  logic             rsp_valid_n, rsp_timeout_n;
  logic [7:0]       rsp_data_n;
  logic             poll_more, poll_timeout;
  logic             irq_meta;

`ifdef SLOT_POLL_EN
  assign poll_more    = lat_read && lat_poll && (rd_data != lat_until) && (poll_cnt < 8'(POLL_MAX));
  assign poll_timeout = lat_read && lat_poll && (rd_data != lat_until);
`else
  logic unused_poll;
  assign poll_more    = 1'b0;
  assign poll_timeout = 1'b0;
  assign unused_poll  = ^{lat_poll, lat_until, poll_cnt};
`endif

  assign req_ready = (state == S_IDLE);

  always_comb begin
    state_n       = state;
    ph_n          = ph_cnt;
    clk_rw_n      = clk_rw;
    slot_x_n      = slot_x;
    ax_d_n        = ax_d;
    r_wx_n        = r_wx;
    bus_dout_n    = bus_dout;
    bus_doe_n     = bus_doe;
    lat_cmd_n     = lat_cmd;
    lat_reg_n     = lat_reg;
    lat_wdata_n   = lat_wdata;
    lat_read_n    = lat_read;
    lat_poll_n    = lat_poll;
    lat_until_n   = lat_until;
    rd_data_n     = rd_data;
    poll_cnt_n    = poll_cnt;
    rsp_valid_n   = 1'b0;
    rsp_data_n    = rsp_data;
    rsp_timeout_n = rsp_timeout;

    if (state == S_IDLE) begin
      if (req_valid) begin
        lat_cmd_n   = req_cmd;
        lat_reg_n   = req_reg;
        lat_wdata_n = req_wdata;
        lat_read_n  = req_read;
        lat_poll_n  = req_poll;
        lat_until_n = poll_until;
        rd_data_n   = 8'h00;
        poll_cnt_n  = 8'h00;
        state_n     = S_SEL;
        ph_n        = PH_LOAD;
        clk_rw_n    = 1'b0;
        slot_x_n    = 1'b0;
        ax_d_n      = 1'b0;
        r_wx_n      = 1'b0;
        bus_dout_n  = 8'hFF;
        bus_doe_n   = 1'b1;
      end
    end else if (ph_cnt != '0) begin
      ph_n = ph_cnt - CNT_W'(1);
    end else if (!clk_rw) begin
      // rising strobe: read data is sampled on this same edge
      clk_rw_n = 1'b1;
      ph_n     = PH_LOAD;
      if (state == S_DATA && lat_read) begin
        rd_data_n  = bus_din;
        poll_cnt_n = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
      end
    end else begin
      clk_rw_n = 1'b0;
      ph_n     = PH_LOAD;
      case (state)
        S_SEL: begin
          state_n    = S_CMD;
          bus_dout_n = lat_cmd;
        end
        S_CMD: begin
          state_n    = S_REG;
          bus_dout_n = lat_reg;
        end
        S_REG: begin
          state_n    = S_DATA;
          ax_d_n     = 1'b1;
          r_wx_n     = lat_read;
          bus_dout_n = lat_wdata;
          bus_doe_n  = !lat_read;
        end
        S_DATA: begin
          if (!poll_more) begin
            state_n    = S_DESEL;
            ax_d_n     = 1'b0;
            r_wx_n     = 1'b0;
            bus_dout_n = 8'hFF;
            bus_doe_n  = 1'b1;
          end
        end
        S_DESEL: begin
          state_n       = S_IDLE;
          slot_x_n      = 1'b1;
          r_wx_n        = 1'b1;
          bus_doe_n     = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_data_n    = lat_read ? rd_data : 8'h00;
          rsp_timeout_n = poll_timeout;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      clk_rw      <= 1'b0;
      slot_x      <= 1'b1;
      ax_d        <= 1'b0;
      r_wx        <= 1'b1;
      bus_dout    <= 8'hFF;
      bus_doe     <= 1'b0;
      lat_cmd     <= 8'h00;
      lat_reg     <= 8'h00;
      lat_wdata   <= 8'h00;
      lat_read    <= 1'b0;
      lat_poll    <= 1'b0;
      lat_until   <= 8'h00;
      rd_data     <= 8'h00;
      poll_cnt    <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      ph_cnt      <= ph_n;
      clk_rw      <= clk_rw_n;
      slot_x      <= slot_x_n;
      ax_d        <= ax_d_n;
      r_wx        <= r_wx_n;
      bus_dout    <= bus_dout_n;
      bus_doe     <= bus_doe_n;
      lat_cmd     <= lat_cmd_n;
      lat_reg     <= lat_reg_n;
      lat_wdata   <= lat_wdata_n;
      lat_read    <= lat_read_n;
      lat_poll    <= lat_poll_n;
      lat_until   <= lat_until_n;
      rd_data     <= rd_data_n;
      poll_cnt    <= poll_cnt_n;
      rsp_valid   <= rsp_valid_n;
      rsp_data    <= rsp_data_n;
      rsp_timeout <= rsp_timeout_n;
    end
  end

  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      irq_meta <= 1'b0;
      irq_sync <= 1'b0;
    end else begin
      irq_meta <= int_x;
      irq_sync <= irq_meta;
    end
  end

endmodule
